// File: rtl/ins_fetch_if.sv
// Fetch-side bus bundle: instruction-memory address/data, redirect request,
// and the decode-facing valid/ready instruction stream.
//   master : the fetch unit (drives pc, ins_*, halted)
//   slave  : the surrounding memory/decode environment
interface ins_fetch_if #(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned INS_W = 32
);
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instruction;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             ins_valid;
    logic             ins_ready;
    logic [INS_W-1:0] ins_data;
    logic [PC_W-1:0]  ins_pc;
    logic             halted;

    modport master (
        output pc, ins_valid, ins_data, ins_pc, halted,
        input  instruction, redirect_valid, redirect_pc, ins_ready
    );

    modport slave (
        input  pc, ins_valid, ins_data, ins_pc, halted,
        output instruction, redirect_valid, redirect_pc, ins_ready
    );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch initiator: drives a word address to a combinational
// instruction memory, buffers {pc, word} pairs in a small prefetch FIFO and
// presents them to decode over valid/ready. A redirect flushes the FIFO and
// restarts fetch at the new address.
// Optional feature: define FETCH_HALT_EN to stop fetching after HALT_WORD is
// pushed (halted is tied 0 otherwise).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus.pc              : registered fetch address to memory
//   bus.instruction     : memory word at bus.pc (same cycle)
//   bus.redirect_valid/ : one-cycle restart request and target address
//   bus.redirect_pc
//   bus.ins_valid/ready : decode handshake; ins_data/ins_pc = FIFO head
//   bus.halted          : fetch stopped on halt word
module ins_fetch #(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     INS_W     = 32,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [INS_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    ins_fetch_if.master  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] word;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PC_W-1:0]  pc_q;
    logic             halted_c;
    logic             pop_c;
    logic             fetch_c;

    // Handshake qualifiers; a full FIFO may still fetch when the head leaves.
    assign pop_c   = (count_q != '0) && bus.ins_ready;
    assign fetch_c = !bus.redirect_valid && !halted_c
                     && ((count_q < CNT_W'(DEPTH)) || pop_c);

    // FIFO storage, pointers, occupancy and fetch address; redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
        end else if (bus.redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= bus.redirect_pc;
        end else begin
            if (fetch_c) begin
                mem_q[wr_ptr_q] <= '{pc: pc_q, word: bus.instruction};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                pc_q            <= pc_q + PC_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(fetch_c) - CNT_W'(pop_c);
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q;

    // Halt word is still pushed; only reset or redirect restarts fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            halted_q <= 1'b0;
        end else if (fetch_c && (bus.instruction == HALT_WORD)) begin
            halted_q <= 1'b1;
        end
    end

    assign halted_c = halted_q;
`else
    logic unused_halt_word;

    assign unused_halt_word = ^HALT_WORD;
    assign halted_c         = 1'b0;
`endif

    assign bus.pc        = pc_q;
    assign bus.halted    = halted_c;
    assign bus.ins_valid = (count_q != '0);
    assign bus.ins_data  = mem_q[rd_ptr_q].word;
    assign bus.ins_pc    = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: combinational memory model (word k =
// 32'h1000_0000 + k), scoreboard of expected {pc, data} pairs popped on every
// accepted instruction, plus direct checks of reset, backpressure, redirect,
// wrap and async reset behaviour.
module tb_ins_fetch;
    logic clk;
    logic rst_n;
    logic halt_at3;
    int   checks;
    int   errors;
    logic [47:0] exp_q[$];

    ins_fetch_if bus ();

    ins_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (halt_at3 && (bus.pc == 16'd3)) bus.instruction = 32'hFFFF_FFFF;
        else                              bus.instruction = 32'h1000_0000 + 32'(bus.pc);
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] p);
        logic [31:0] d;
        d = (halt_at3 && p == 16'd3) ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(p);
        exp_q.push_back({p, d});
    endtask

    // Compare an accepted head against the scoreboard, then advance one cycle.
    task automatic cycle();
        logic [47:0] e;
        if (bus.ins_valid && bus.ins_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", 48'(bus.ins_pc), 48'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", 48'(bus.ins_pc), 48'(e[47:32]));
                chk("pop_data", 48'(bus.ins_data), 48'(e[31:0]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        halt_at3 = 1'b0;
        rst_n = 1'b0;
        bus.ins_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;

        // Reset values
        #1;
        chk("rst_pc", 48'(bus.pc), 48'h0);
        chk("rst_valid", 48'(bus.ins_valid), 48'h0);
        chk("rst_data", 48'(bus.ins_data), 48'h0);
        chk("rst_ins_pc", 48'(bus.ins_pc), 48'h0);
        chk("rst_halted", 48'(bus.halted), 48'h0);

        // Stream with ins_ready=1
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) push_exp(16'(k));
        chk("valid_before_edge", 48'(bus.ins_valid), 48'h0);
        @(posedge clk);
        @(negedge clk);
        chk("first_valid", 48'(bus.ins_valid), 48'h1);
        for (int k = 0; k < 6; k++) begin
            chk("stream_valid", 48'(bus.ins_valid), 48'h1);
            cycle();
        end
        bus.ins_ready = 1'b0;
        chk("stream_drained", 48'(exp_q.size()), 48'h0);

        // Backpressure from reset
        rst_n = 1'b0;
        #1;
        chk("bp_rst_valid", 48'(bus.ins_valid), 48'h0);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_pc", 48'(bus.pc), 48'((k < 2) ? k : 2));
            chk("bp_head_pc", 48'(bus.ins_pc), 48'h0);
            chk("bp_head_data", 48'(bus.ins_data), 48'h1000_0000);
        end
        for (int k = 0; k < 3; k++) push_exp(16'(k));
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        bus.ins_ready = 1'b0;
        chk("bp_drained", 48'(exp_q.size()), 48'h0);
        chk("bp_pc_after", 48'(bus.pc), 48'h5);
        chk("bp_head_3", 48'(bus.ins_pc), 48'h3);

        // Redirect while pc 3,4 are buffered
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0008;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("redir_valid_low", 48'(bus.ins_valid), 48'h0);
        chk("redir_pc", 48'(bus.pc), 48'h8);
        bus.ins_ready = 1'b1;
        for (int k = 8; k < 11; k++) push_exp(16'(k));
        cycle();
        for (int k = 0; k < 3; k++) cycle();
        bus.ins_ready = 1'b0;
        chk("redir_drained", 48'(exp_q.size()), 48'h0);

        // Back-to-back redirects, last one wins, then address wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        cycle();
        bus.redirect_pc = 16'hFFFE;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("wrap_valid_low", 48'(bus.ins_valid), 48'h0);
        chk("wrap_pc", 48'(bus.pc), 48'hFFFE);
        bus.ins_ready = 1'b1;
        push_exp(16'hFFFE);
        push_exp(16'hFFFF);
        push_exp(16'h0000);
        push_exp(16'h0001);
        for (int k = 0; k < 5; k++) cycle();
        bus.ins_ready = 1'b0;
        chk("wrap_drained", 48'(exp_q.size()), 48'h0);
        cycle();

        // Async reset between edges with a full FIFO
        chk("pre_rst_pc", 48'(bus.pc), 48'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 48'(bus.ins_valid), 48'h0);
        chk("arst_pc", 48'(bus.pc), 48'h0);
        chk("arst_ins_pc", 48'(bus.ins_pc), 48'h0);
        chk("arst_data", 48'(bus.ins_data), 48'h0);
        #1;
        rst_n = 1'b1;
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(16'(k));
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) cycle();
        bus.ins_ready = 1'b0;
        chk("arst_drained", 48'(exp_q.size()), 48'h0);
        chk("halted_default", 48'(bus.halted), 48'h0);

`ifdef FETCH_HALT_EN
        // Halt word at address 3
        halt_at3 = 1'b1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(16'(k));
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 6; k++) cycle();
        chk("halt_drained", 48'(exp_q.size()), 48'h0);
        chk("halt_flag", 48'(bus.halted), 48'h1);
        chk("halt_pc", 48'(bus.pc), 48'h4);
        chk("halt_valid", 48'(bus.ins_valid), 48'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0000;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("unhalt_flag", 48'(bus.halted), 48'h0);
        for (int k = 0; k < 3; k++) push_exp(16'(k));
        cycle();
        for (int k = 0; k < 3; k++) cycle();
        chk("unhalt_drained", 48'(exp_q.size()), 48'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
- Instruction fetch initiator that sits between the PC datapath and the instruction memory.
- Drives a word address to the instruction memory, whose read is combinational and returns the word in the same cycle. Each returned 32-bit word is captured, tagged with its address, and buffered in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and restarting fetch at the new address.

Parameters:
- PC_W, 16, width of the word address driven to instruction memory.
- INS_W, 32, instruction word width.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 0, fetch address loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, halt encoding; used only when FETCH_HALT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pc  output  PC_W  word address to instruction memory (registered).
- instruction  input  INS_W  word read from memory at pc, valid in the same cycle.
- redirect_valid  input  1  one-cycle request to restart fetch.
- redirect_pc  input  PC_W  new fetch address, sampled when redirect_valid=1.
- ins_valid  output  1  FIFO head holds an instruction.
- ins_ready  input  1  decode accepts the head this cycle.
- ins_data  output  INS_W  head instruction.
- ins_pc  output  PC_W  address of head instruction.
- halted  output  1  fetch stopped on halt word (tied 0 without FETCH_HALT_EN).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, FIFO count=0, read/write pointers=0, all FIFO storage=0.
  - ins_valid=0, ins_data=0, ins_pc=0, halted=0.
  - Outputs take these values immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards all buffered words.
- Signal definitions:
  - pop = ins_valid & ins_ready.
  - fetch = ~redirect_valid & ~halted & (count<DEPTH | pop).
- On fetch at a clock edge:
  - Push {pc, instruction} at the write pointer.
  - pc <= pc+1, modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000.
- On pop: advance the read pointer.
- Count update:
  - count' = count + fetch − pop.
  - Simultaneous push and pop when full is legal and leaves count=DEPTH.
- Outputs:
  - ins_valid = (count != 0).
  - ins_data and ins_pc come combinationally from the head entry.
- Latency:
  - The first instruction (RESET_PC) is valid in the cycle after the first clock edge following reset release.
  - Steady-state throughput is one instruction per cycle while ins_ready=1.
- Backpressure:
  - With ins_ready=0, fetch continues until count=DEPTH, then pc holds.
  - ins_valid, ins_data and ins_pc stay stable until popped.
- Redirect (highest priority):
  - At the edge: count<=0, pointers<=0, pc<=redirect_pc, halted<=0; no push that cycle.
  - A pop coincident with the redirect completes from the consumer side, but the rest of the FIFO is flushed.
  - ins_valid=0 in the cycle after the redirect edge. The instruction at redirect_pc is valid one cycle later.
  - redirect_valid on consecutive cycles: the last one wins.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - When a pushed word equals HALT_WORD, it is still pushed.
  - halted<=1 at that same edge, and fetch stops; pc holds at halt address+1.
  - Buffered entries, including the halt word, still drain normally.
  - Only reset or a redirect clears halted.
- Not defined:
  - No comparison logic is generated and halted is tied 0.
  - HALT_WORD is fetched like any other word.

Test Plan:
- Reset then stream:
  - Stimulus: memory word k = 32'h1000_0000+k, ins_ready=1.
  - Response: ins_pc sequence 0,1,2,3…; ins_data 32'h1000_0000, 32'h1000_0001, … one per cycle; first valid one cycle after the first edge.
- Backpressure:
  - Stimulus: hold ins_ready=0 for 5 cycles from reset.
  - Response: count reaches 2; pc stops at 2; ins_pc stays 0 with stable data; release gives 0,1,2 with no gap or duplicate.
- Redirect with full FIFO:
  - Stimulus: redirect_pc=16'h0008 while entries at pc 3,4 are buffered.
  - Response: ins_valid=0 next cycle; then ins_pc=8, ins_data=mem[8]; pc 3 and 4 never delivered after the redirect edge.
- Wrap:
  - Stimulus: redirect to 16'hFFFE.
  - Response: delivered ins_pc FFFE, FFFF, 0000, 0001.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges while count=2.
  - Response: ins_valid=0 and pc=RESET_PC immediately; restart from 0 after release.
- FETCH_HALT_EN:
  - Stimulus: mem[3]=32'hFFFF_FFFF.
  - Response: words 0–3 delivered; halted=1; pc frozen at 4.
  - Stimulus: redirect to 0.
  - Response: halted=0 and fetch resumes at 0.
